regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the register file's single write port between two writeback sources.
//   Port 0 is the in-order pipeline WB stage. Port 1 is the long-latency unit (MUL/DIV, load miss).
//   Also holds a destination scoreboard that marks rd of issued long-latency ops as pending.
//   Issue logic queries the scoreboard for RAW stalls. Sits between the WB sources and the register file.
// PARAMETERS
//   DATA_W        32  writeback data width
//   STARVE_LIMIT  4   consecutive cycles port 1 may wait before it is force-granted (legal 1..15)
// PORTS
//   clk_i          in   1       clock
//   rst_n          in   1       async active-low reset
//   wb0_valid_i    in   1       pipeline WB request
//   wb0_rd_i       in   5       pipeline WB destination
//   wb0_data_i     in   DATA_W  pipeline WB data
//   wb0_ready_o    out  1       port 0 write accepted this cycle
//   wb1_valid_i    in   1       long-latency unit WB request
//   wb1_rd_i       in   5       long-latency unit WB destination
//   wb1_data_i     in   DATA_W  long-latency unit WB data
//   wb1_ready_o    out  1       port 1 write accepted this cycle
//   mark_valid_i   in   1       long-latency op issued; mark mark_rd_i pending
//   mark_rd_i      in   5       destination to mark
//   rs1_i, rs2_i   in   5       source regs of the instruction in decode
//   rs1_pend_o     out  1       rs1 has an outstanding long-latency write
//   rs2_pend_o     out  1       rs2 has an outstanding long-latency write
//   RegWrite_o     out  1       register file write enable
//   RDaddr_o       out  5       register file write address
//   RDdata_o       out  DATA_W  register file write data
// BEHAVIOUR
//   - Interface: one clock clk_i; rst_n is asynchronous and active-low.
//   - Reset (rst_n low, asynchronous): scoreboard[31:0]=0 and starve_cnt=0.
//     While rst_n is low: wb0_ready_o=0, wb1_ready_o=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0, rsX_pend_o=0.
//   - Grant is combinational, zero latency. At most one grant per cycle.
//     Default priority is port 0. Port 1 is granted when wb0_valid_i=0.
//     Port 1 is also granted when starve_cnt==STARVE_LIMIT; port 0 then sees ready=0 and must hold its request.
//   - A handshake completes when valid&ready. Requesters hold rd/data stable until accepted.
//   - Outputs when a port is granted: RegWrite_o=1, RDaddr_o/RDdata_o driven from the granted port.
//     Exception: if the granted rd==0, the write is accepted (ready=1) but RegWrite_o=0.
//     With no grant: RegWrite_o=0, RDaddr_o=0, RDdata_o=0.
//   - starve_cnt: 4-bit counter.
//     Increments when wb1_valid_i=1 and port 1 is not granted.
//     Clears to 0 when port 1 is granted or wb1_valid_i=0.
//     Never exceeds STARVE_LIMIT.
//   - Scoreboard, updated at clock edge:
//     mark_valid_i sets bit mark_rd_i; mark_rd_i==0 is ignored.
//     A port 1 handshake clears bit wb1_rd_i.
//     If a mark and a clear hit the same register in the same cycle, the mark wins (bit stays 1).
//     Marking an already-pending register is illegal; issue logic must stall on pend before issuing.
//   - rsX_pend_o = scoreboard[rsX_i]. x0 always reads 0.
// CONFIGURATION
//   WB_BYPASS_EN defined:
//     rsX_pend_o is also forced 0 in the cycle port 1 is granted with wb1_rd_i==rsX_i.
//     The register file forwards that same-cycle write, so the stall is one cycle shorter.
//   WB_BYPASS_EN undefined:
//     rsX_pend_o follows the registered scoreboard only; pend drops the cycle after the write.
// TESTING
//   1. Port 0 only: wb0 valid, rd=5, data=0xDEADBEEF -> wb0_ready_o=1, RegWrite_o=1, RDaddr_o=5,
//      RDdata_o=0xDEADBEEF, same cycle.
//   2. Both valid continuously, STARVE_LIMIT=4 -> port 0 granted 4 cycles, port 1 granted on cycle 5,
//      wb0_ready_o=0 that cycle, pattern repeats.
//   3. mark rd=7, then rs1_i=7 -> rs1_pend_o=1 until port 1 writes rd=7.
//      With WB_BYPASS_EN, pend=0 in the grant cycle; without it, pend=0 one cycle later.
//   4. Same cycle: mark rd=9 and port 1 write rd=9 -> bit 9 remains set.
//      Separately, mark rd=0 -> rs1_i=0 gives pend=0.
//   5. Port 1 write rd=0 -> wb1_ready_o=1, RegWrite_o=0, scoreboard unchanged.
//   6. Assert rst_n=0 mid-stream (starve_cnt=3, bits 3 and 12 pending) -> outputs 0 immediately.
//      After release, all pend=0 and port 0 is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB
// stage (port 0) and the long-latency unit (port 1), with a starvation
// limit for port 1, and keeps a destination scoreboard of long-latency rd's.
// Ports: clk_i, rst_n (async, active-low); wb0_*/wb1_* valid/rd/data in,
// ready out; mark_valid_i/mark_rd_i set scoreboard bits; rs1_i/rs2_i query
// it via rs1_pend_o/rs2_pend_o; RegWrite_o/RDaddr_o/RDdata_o drive the
// register file write port.
// Optional macro WB_BYPASS_EN: suppress pend in the cycle port 1 writes
// the queried register, since the register file forwards that write.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              wb0_valid_i,
  input  logic [4:0]        wb0_rd_i,
  input  logic [DATA_W-1:0] wb0_data_i,
  output logic              wb0_ready_o,
  input  logic              wb1_valid_i,
  input  logic [4:0]        wb1_rd_i,
  input  logic [DATA_W-1:0] wb1_data_i,
  output logic              wb1_ready_o,
  input  logic              mark_valid_i,
  input  logic [4:0]        mark_rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  output logic              rs1_pend_o,
  output logic              rs2_pend_o,
  output logic              RegWrite_o,
  output logic [4:0]        RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]  r_starve;
  logic [31:0] r_sb;
  logic [31:0] w_sb_nxt;
  logic        w_force;
  logic        w_g0;
  logic        w_g1;
  logic        w_byp1;
  logic        w_byp2;

  // Port 1 wins when port 0 is idle or it has waited the full limit.
  // Grants are gated by rst_n so every output is 0 during reset.
  assign w_force = (r_starve == LIM);
  assign w_g1 = rst_n & wb1_valid_i & (~wb0_valid_i | w_force);
  assign w_g0 = rst_n & wb0_valid_i & ~w_g1;

  assign wb0_ready_o = w_g0;
  assign wb1_ready_o = w_g1;

  always_comb begin
    RegWrite_o = 1'b0;
    RDaddr_o   = '0;
    RDdata_o   = '0;
    if (w_g1) begin
      RegWrite_o = (wb1_rd_i != 5'd0);
      RDaddr_o   = wb1_rd_i;
      RDdata_o   = wb1_data_i;
    end else if (w_g0) begin
      RegWrite_o = (wb0_rd_i != 5'd0);
      RDaddr_o   = wb0_rd_i;
      RDdata_o   = wb0_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!wb1_valid_i || w_g1) begin
      r_starve <= '0;
    end else if (r_starve != LIM) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Clear is applied before the mark so a same-register collision keeps
  // the bit set for the newly issued op.
  always_comb begin
    w_sb_nxt = r_sb;
    if (w_g1) begin
      w_sb_nxt[wb1_rd_i] = 1'b0;
    end
    if (mark_valid_i && (mark_rd_i != 5'd0)) begin
      w_sb_nxt[mark_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

`ifdef WB_BYPASS_EN
  assign w_byp1 = w_g1 & (wb1_rd_i == rs1_i);
  assign w_byp2 = w_g1 & (wb1_rd_i == rs2_i);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign rs1_pend_o = rst_n & (rs1_i != 5'd0) & r_sb[rs1_i] & ~w_byp1;
  assign rs2_pend_o = rst_n & (rs2_i != 5'd0) & r_sb[rs2_i] & ~w_byp2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a
// behavioural model of grants, starvation waiting and the scoreboard.
module tb_regfile_wb_arbiter;

  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0, mv = 1'b0;
  logic [4:0]    rd0 = '0, rd1 = '0, mrd = '0, rs1 = '0, rs2 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          rdy0, rdy1, p1, p2, we;
  logic [4:0]    addr;
  logic [DW-1:0] data;

  int n_vec = 0;
  int n_bad = 0;

  bit [31:0] m_sb;
  int        m_wait;

  regfile_wb_arbiter #(.DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .wb0_valid_i(v0), .wb0_rd_i(rd0), .wb0_data_i(d0),
    .wb0_ready_o(rdy0),
    .wb1_valid_i(v1), .wb1_rd_i(rd1), .wb1_data_i(d1),
    .wb1_ready_o(rdy1),
    .mark_valid_i(mv), .mark_rd_i(mrd),
    .rs1_i(rs1), .rs2_i(rs2),
    .rs1_pend_o(p1), .rs2_pend_o(p2),
    .RegWrite_o(we), .RDaddr_o(addr), .RDdata_o(data)
  );

  always #5 clk = ~clk;

  function automatic bit m_g1();
    return v1 && (!v0 || m_wait == LIM);
  endfunction

  function automatic bit m_pend(input logic [4:0] rs);
    bit pd;
    pd = (rs != 0) && m_sb[rs];
`ifdef WB_BYPASS_EN
    if (m_g1() && rd1 == rs) pd = 0;
`endif
    return pd;
  endfunction

  // Advance one clock edge, updating the model from the inputs held there.
  task automatic tick();
    bit g1;
    g1 = m_g1();
    @(posedge clk);
    if (v1 && !g1) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
    else m_wait = 0;
    if (g1) m_sb[rd1] = 0;
    if (mv && mrd != 0) m_sb[mrd] = 1;
    @(negedge clk);
  endtask

  task automatic idle();
    v0 = 0; v1 = 0; mv = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    v0 = 1; rd0 = 5; d0 = 32'h1234;
    v1 = 1; rd1 = 6; rs1 = 3; rs2 = 4;
    #1;
    n_vec++;
    if ({rdy0, rdy1, we, addr, data, p1, p2} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got %h/%h/%h/%h/%h/%h/%h want all 0",
               rdy0, rdy1, we, addr, data, p1, p2);
    end
    repeat (2) @(negedge clk);
    idle();
    rst_n = 1;
    m_sb = 0; m_wait = 0;
  endtask

  task automatic test_port0();
    idle();
    v0 = 1; rd0 = 5; d0 = 32'hDEADBEEF;
    #1;
    n_vec++;
    if ({rdy0, rdy1, we, addr} !== {1'b1, 1'b0, 1'b1, 5'd5}
        || data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL port0 got rdy0=%b rdy1=%b we=%b a=%0d d=%h want 1 0 1 5 deadbeef",
               rdy0, rdy1, we, addr, data);
    end
    tick();
    idle();
  endtask

  task automatic test_starve();
    bit e1;
    idle();
    tick();
    v0 = 1; rd0 = 1; d0 = 32'hA;
    v1 = 1; rd1 = 2; d1 = 32'hB;
    for (int k = 0; k < 10; k++) begin
      e1 = (k % 5 == 4);
      #1;
      n_vec++;
      if (rdy0 !== !e1 || rdy1 !== e1 || addr !== (e1 ? 5'd2 : 5'd1)) begin
        n_bad++;
        $display("FAIL starve k=%0d got rdy0=%b rdy1=%b a=%0d want %b %b %0d",
                 k, rdy0, rdy1, addr, !e1, e1, e1 ? 2 : 1);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_pend();
    bit ex;
    idle();
    mv = 1; mrd = 7;
    tick();
    mv = 0; rs1 = 7; rs2 = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (p1 !== 1'b1 || p2 !== 1'b0) begin
        n_bad++;
        $display("FAIL pend_hold k=%0d got p1=%b p2=%b want 1 0", k, p1, p2);
      end
      tick();
    end
    v1 = 1; rd1 = 7; d1 = 32'h77;
`ifdef WB_BYPASS_EN
    ex = 0;
`else
    ex = 1;
`endif
    #1;
    n_vec++;
    if (p1 !== ex || rdy1 !== 1'b1 || we !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_grant got p1=%b rdy1=%b we=%b want %b 1 1",
               p1, rdy1, we, ex);
    end
    tick();
    v1 = 0;
    #1;
    n_vec++;
    if (p1 !== 1'b0) begin
      n_bad++;
      $display("FAIL pend_after got %b want 0", p1);
    end
    tick();
  endtask

  task automatic test_mark_clear();
    idle();
    mv = 1; mrd = 9;
    v1 = 1; rd1 = 9; d1 = 32'h99;
    tick();
    idle();
    rs1 = 9;
    #1;
    n_vec++;
    if (p1 !== 1'b1) begin
      n_bad++;
      $display("FAIL mark_wins got %b want 1", p1);
    end
    v1 = 1; rd1 = 9;
    tick();
    idle();
    mv = 1; mrd = 0;
    tick();
    mv = 0; rs1 = 0; rs2 = 0;
    #1;
    n_vec++;
    if (p1 !== 1'b0 || p2 !== 1'b0) begin
      n_bad++;
      $display("FAIL mark_x0 got %b %b want 0 0", p1, p2);
    end
    rs1 = 9;
    #1;
    n_vec++;
    if (p1 !== 1'b0) begin
      n_bad++;
      $display("FAIL clear9 got %b want 0", p1);
    end
    tick();
  endtask

  task automatic test_rd0();
    idle();
    mv = 1; mrd = 4;
    tick();
    mv = 0;
    v1 = 1; rd1 = 0; d1 = 32'h55;
    #1;
    n_vec++;
    if (rdy1 !== 1'b1 || we !== 1'b0 || rdy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL rd0 got rdy1=%b we=%b rdy0=%b want 1 0 0",
               rdy1, we, rdy0);
    end
    tick();
    idle();
    rs1 = 4; rs2 = 0;
    #1;
    n_vec++;
    if (p1 !== 1'b1 || p2 !== 1'b0) begin
      n_bad++;
      $display("FAIL rd0_sb got %b %b want 1 0", p1, p2);
    end
    v1 = 1; rd1 = 4;
    tick();
    idle();
  endtask

  task automatic test_random();
    bit g1, g0, ewe;
    logic [4:0] erd, ea;
    logic [DW-1:0] ed;
    idle();
    for (int k = 0; k < 400; k++) begin
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1; rd0 = 5'($urandom); d0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1; rd1 = 5'($urandom); d1 = $urandom;
      end
      mrd = 5'($urandom);
      mv = ($urandom_range(0, 3) == 0) && !m_sb[mrd];
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      g1 = m_g1();
      g0 = v0 && !g1;
      erd = g1 ? rd1 : rd0;
      ewe = (g0 || g1) && erd != 0;
      ea = (g0 || g1) ? erd : 5'd0;
      ed = g1 ? d1 : (g0 ? d0 : '0);
      #1;
      n_vec++;
      if (rdy0 !== g0 || rdy1 !== g1 || we !== ewe
          || addr !== ea || data !== ed) begin
        n_bad++;
        $display("FAIL rnd_wb k=%0d got %b %b %b %0d %h want %b %b %b %0d %h",
                 k, rdy0, rdy1, we, addr, data, g0, g1, ewe, ea, ed);
      end
      n_vec++;
      if (p1 !== m_pend(rs1) || p2 !== m_pend(rs2)) begin
        n_bad++;
        $display("FAIL rnd_pend k=%0d got %b %b want %b %b",
                 k, p1, p2, m_pend(rs1), m_pend(rs2));
      end
      tick();
      if (g0) v0 = 0;
      if (g1) v1 = 0;
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int r = 1; r < 32; r++) begin
      v1 = 1; rd1 = 5'(r);
      tick();
    end
    idle();
    mv = 1; mrd = 3;
    tick();
    mrd = 12;
    tick();
    mv = 0;
    v0 = 1; rd0 = 1; d0 = 32'h1;
    v1 = 1; rd1 = 20; d1 = 32'h2;
    repeat (3) tick();
    rs1 = 3; rs2 = 12;
    #1;
    n_vec++;
    if (p1 !== 1'b1 || p2 !== 1'b1 || m_wait != 3 || rdy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_rst got p=%b%b rdy0=%b want 11 1", p1, p2, rdy0);
    end
    #2;
    rst_n = 0;
    #1;
    n_vec++;
    if ({rdy0, rdy1, we, addr, data, p1, p2} !== '0) begin
      n_bad++;
      $display("FAIL mid_rst got %b %b %b %0d %h %b %b want all 0",
               rdy0, rdy1, we, addr, data, p1, p2);
    end
    @(negedge clk);
    rst_n = 1;
    m_sb = 0; m_wait = 0;
    #1;
    n_vec++;
    if (p1 !== 1'b0 || p2 !== 1'b0 || rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst got p=%b%b rdy=%b%b want 00 10",
               p1, p2, rdy0, rdy1);
    end
    tick();
    idle();
  endtask

  initial begin
    m_sb = 0;
    m_wait = 0;
    test_reset();
    test_port0();
    test_starve();
    test_pend();
    test_mark_clear();
    test_rd0();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
